// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - in-order ALU command queue with invalid-opcode filtering
// Optional: define ALU_ISSUE_ERRCNT_EN to add the saturating err_count output.
module alu_issue_queue #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [1:0]               in_op,
    input  logic [WIDTH-1:0]         in_x,
    input  logic [WIDTH-1:0]         in_z,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [1:0]               alu_control,
    output logic [WIDTH-1:0]         x,
    output logic [WIDTH-1:0]         z,
    output logic                     err_pulse,
`ifdef ALU_ISSUE_ERRCNT_EN
    output logic [7:0]               err_count,
`endif
    output logic [$clog2(DEPTH):0]   count
);

    localparam int CNT_W  = $clog2(DEPTH) + 1;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FIFO_D = DEPTH - 1;

    typedef struct packed {
        logic [1:0]       op;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] z;
    } cmd_t;

    cmd_t             mem [FIFO_D];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;

    logic accept;
    logic drop;
    logic push;
    logic pop;
    logic fifo_empty;
    logic bypass;
    logic fifo_wr;
    logic fifo_rd;
    logic [CNT_W-1:0] count_nxt;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_D - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // While out_valid is low the FIFO is always empty, so count alone tells FIFO occupancy.
    always_comb begin
        in_ready   = (count < CNT_W'(DEPTH));
        accept     = in_valid && in_ready;
        drop       = accept && (in_op == 2'd3);
        push       = accept && (in_op != 2'd3);
        pop        = out_valid && out_ready;
        fifo_empty = (count <= CNT_W'(1));
        bypass     = push && (!out_valid || (pop && fifo_empty));
        fifo_wr    = push && !bypass;
        fifo_rd    = pop && !fifo_empty;
        count_nxt  = count;
        if (push && !pop) begin
            count_nxt = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            alu_control <= '0;
            x           <= '0;
            z           <= '0;
            err_pulse   <= 1'b0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            err_pulse <= drop;
            count     <= count_nxt;
            if (fifo_rd) begin
                out_valid   <= 1'b1;
                alu_control <= mem[rd_ptr].op;
                x           <= mem[rd_ptr].x;
                z           <= mem[rd_ptr].z;
                rd_ptr      <= ptr_inc(rd_ptr);
            end else if (bypass) begin
                out_valid   <= 1'b1;
                alu_control <= in_op;
                x           <= in_x;
                z           <= in_z;
            end else if (pop) begin
                out_valid <= 1'b0;
            end
            if (fifo_wr) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
        end
    end

    // Payload storage needs no reset: pointers and count define what is live.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= '{op: in_op, x: in_x, z: in_z};
        end
    end

`ifdef ALU_ISSUE_ERRCNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (drop && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_queue.sv
// tb/tb_alu_issue_queue.sv - directed self-checking bench for alu_issue_queue
module tb_alu_issue_queue;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] in_x;
    logic [WIDTH-1:0] in_z;
    logic             out_valid;
    logic             out_ready;
    logic [1:0]       alu_control;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] z;
    logic             err_pulse;
    logic [2:0]       count;
`ifdef ALU_ISSUE_ERRCNT_EN
    logic [7:0]       err_count;
`endif

    int checks   = 0;
    int failures = 0;

    alu_issue_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_x        (in_x),
        .in_z        (in_z),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .alu_control (alu_control),
        .x           (x),
        .z           (z),
        .err_pulse   (err_pulse),
`ifdef ALU_ISSUE_ERRCNT_EN
        .err_count   (err_count),
`endif
        .count       (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [1:0] op, input int vx, input int vz);
        in_valid = 1'b1;
        in_op    = op;
        in_x     = WIDTH'(vx);
        in_z     = WIDTH'(vz);
    endtask

    int exp_x  [12];
    int exp_op [12];
    int pulses;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_x = '0; in_z = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_x", 32'(x), 0);
        chk("rst_err_pulse", 32'(err_pulse), 0);
        #9 rst_n = 1'b1;
        tick();

        // single command, held until consumed
        offer(2'd0, 5, 3);
        tick();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 1);
        chk("single_op", 32'(alu_control), 0);
        chk("single_x", 32'(x), 5);
        chk("single_z", 32'(z), 3);
        chk("single_count", 32'(count), 1);
        tick(); tick();
        chk("hold_x", 32'(x), 5);
        chk("hold_valid", 32'(out_valid), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("single_pop_valid", 32'(out_valid), 0);
        chk("single_pop_count", 32'(count), 0);

        // fill to DEPTH, fifth offer refused, then drain in order
        for (int i = 1; i <= 4; i++) begin
            offer(2'd0, i, 2 * i);
            chk("fill_in_ready", 32'(in_ready), 1);
            tick();
        end
        chk("full_count", 32'(count), 4);
        chk("full_in_ready", 32'(in_ready), 0);
        offer(2'd1, 5, 5);
        tick();
        in_valid = 1'b0;
        chk("full_refuse_count", 32'(count), 4);
        out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("drain_x", 32'(x), 32'(i));
            chk("drain_z", 32'(z), 32'(2 * i));
            chk("drain_valid", 32'(out_valid), 1);
            tick();
        end
        out_ready = 1'b0;
        chk("drain_empty_valid", 32'(out_valid), 0);
        chk("drain_empty_count", 32'(count), 0);

        // invalid opcode dropped, followed by a valid one
        offer(2'd3, 7, 7);
        tick();
        chk("inv_err_pulse", 32'(err_pulse), 1);
        chk("inv_count", 32'(count), 0);
        chk("inv_out_valid", 32'(out_valid), 0);
        offer(2'd1, 9, 2);
        tick();
        in_valid = 1'b0;
        chk("inv_pulse_once", 32'(err_pulse), 0);
        chk("inv_next_count", 32'(count), 1);
        chk("inv_next_op", 32'(alu_control), 1);
        chk("inv_next_x", 32'(x), 9);
`ifdef ALU_ISSUE_ERRCNT_EN
        chk("inv_err_count", 32'(err_count), 1);
`endif

        // simultaneous push/pop at count 2 across pointer wrap
        offer(2'd0, 20, 0);
        tick();
        chk("pp_start_count", 32'(count), 2);
        exp_x[0] = 9;  exp_op[0] = 1;
        exp_x[1] = 20; exp_op[1] = 0;
        for (int i = 0; i < 10; i++) begin
            exp_x[i + 2]  = 100 + i;
            exp_op[i + 2] = i % 3;
        end
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            offer(2'(exp_op[i + 2]), exp_x[i + 2], i);
            chk("pp_x", 32'(x), 32'(exp_x[i]));
            chk("pp_op", 32'(alu_control), 32'(exp_op[i]));
            chk("pp_count", 32'(count), 2);
            chk("pp_in_ready", 32'(in_ready), 1);
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b0;
        chk("pp_end_count", 32'(count), 2);
        chk("pp_end_x", 32'(x), 108);
        chk("pp_end_op", 32'(alu_control), 2);

        // asynchronous reset mid-operation
        offer(2'd2, 50, 1);
        tick();
        in_valid = 1'b0;
        chk("pre_rst_count", 32'(count), 3);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_in_ready", 32'(in_ready), 1);
        chk("arst_x", 32'(x), 0);
        #1 rst_n = 1'b1;
        tick();
        offer(2'd0, 77, 1);
        tick();
        in_valid = 1'b0;
        chk("post_rst_x", 32'(x), 77);
        chk("post_rst_count", 32'(count), 1);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("post_rst_no_stale", 32'(out_valid), 0);
        chk("post_rst_count0", 32'(count), 0);

        // back-to-back invalids keep err_pulse high; optional saturation
        pulses = 0;
        for (int i = 0; i < 260; i++) begin
            offer(2'd3, i, i);
            tick();
            if (err_pulse === 1'b1) pulses++;
        end
        in_valid = 1'b0;
        chk("b2b_pulses", 32'(pulses), 260);
        chk("b2b_count", 32'(count), 0);
        tick();
        chk("b2b_pulse_end", 32'(err_pulse), 0);
`ifdef ALU_ISSUE_ERRCNT_EN
        chk("err_count_sat", 32'(err_count), 255);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

In-order command queue that sits directly upstream of the combinational ALU stage. It buffers opcode/operand commands from the producer via a valid/ready handshake and presents one command at a time as registered `alu_control`, `x` and `z`. Commands carrying the unused opcode 2'd3 are filtered out and flagged here, so invalid commands never reach the ALU. The downstream ALU consumes the head command with its own valid/ready handshake.

## Interface

Parameters:
- `WIDTH`, 8, operand width in bits.
- `DEPTH`, 4, total command storage including the output register; power of 2, at least 2.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: producer offers a command.
- `in_ready` output 1: queue can accept a command.
- `in_op` input 2: ALU opcode (0 add, 1 sub, 2 mul, 3 invalid).
- `in_x` input WIDTH: operand x.
- `in_z` input WIDTH: operand z.
- `out_valid` output 1: `alu_control`/`x`/`z` hold a valid command.
- `out_ready` input 1: ALU consumes the head command.
- `alu_control` output 2: head opcode, registered.
- `x` output WIDTH: head operand x, registered.
- `z` output WIDTH: head operand z, registered.
- `err_pulse` output 1: one-cycle pulse when an invalid command is dropped.
- `count` output $clog2(DEPTH)+1: stored commands, including the output register.
- `err_count` output 8: present only with `ALU_ISSUE_ERRCNT_EN`.

## Operation

- **Storage:** one output register plus a (DEPTH-1)-entry circular FIFO with wrapping read and write pointers.
- **Accept:** a command is accepted when `in_valid && in_ready`.
- **Ready:** `in_ready = (count < DEPTH)`. It is registered-state-derived; there is no combinational path from `out_ready`.
- **Invalid opcode (`in_op == 2'd3`):**
  - The handshake still completes.
  - The command is not stored and `count` is unchanged.
  - `err_pulse` is high in the cycle after acceptance.
- **Valid command routing:**
  - If the output register is empty, or is being popped this cycle while the FIFO is empty, the command loads directly into the output register (bypass).
  - Otherwise it is written to the FIFO tail.
- **Pop:** occurs on `out_valid && out_ready`. The output register reloads from the FIFO head if the FIFO is non-empty; otherwise `out_valid` falls.
- **Ordering:** strict FIFO order for valid commands.
- **Output stability:** `alu_control`/`x`/`z` are stable while `out_valid && !out_ready`.
- **Simultaneous push and pop:** `count` is unchanged, and both operations complete in the same cycle.
- **Full (`count == DEPTH`):** `in_ready` is 0 even if a pop occurs that cycle. The pop frees a slot for the next cycle.
- **Empty (`count == 0`):** `out_valid` is 0, and `out_ready` is ignored.

## Timing

- **Reset:** asserting `rst_n` low immediately clears all of the following, and all queued commands are discarded, including mid-handshake:
  - `out_valid`, `alu_control`, `x`, `z`, `err_pulse`, `count` and `err_count` go to 0.
  - Pointers go to 0.
  - `in_ready` goes to 1.
- **Latency:** a valid command accepted at edge N into an empty queue has `out_valid` = 1 after edge N.
- **Throughput:** one accept and one pop per cycle sustained.
- **Update point:** `count` updates on the same edge as the push or pop.
- **Error signalling:** `err_pulse` is asserted for exactly one cycle per dropped command. Back-to-back invalid commands give a continuously high `err_pulse`.

## Configuration

- **`ALU_ISSUE_ERRCNT_EN` defined:**
  - The `err_count` port exists.
  - It increments on each dropped invalid command, on the same edge that raises `err_pulse`.
  - It saturates at 255 and is cleared only by reset.
- **Undefined:** the `err_count` port and its counter are absent; `err_pulse` behaviour is identical in both cases.

## Test plan

- **Single command:** after reset, push op=0, x=8'd5, z=8'd3 with `out_ready`=0.
  - Expect `out_valid`=1, `alu_control`=0, x=5, z=3 and `count`=1 one cycle later.
  - Outputs hold until `out_ready`=1.
- **Fill and ordering:** push 4 valid commands (x=1..4) with `out_ready`=0.
  - Expect `count`=4 and `in_ready`=0; the 5th offer is not accepted.
  - Then hold `out_ready`=1; expect x=1,2,3,4 on consecutive cycles, and `out_valid`=0 after the last.
- **Invalid opcode:** push op=3 then op=1, x=9.
  - Expect `err_pulse` high for 1 cycle.
  - `count` never counts op=3; the head shows `alu_control`=1, x=9.
  - With the macro defined, `err_count`=1.
- **Simultaneous push/pop and wrap:** at `count`=2, stream 10 valid commands with `in_valid`=`out_ready`=1 each cycle.
  - Expect `count` to stay 2 and outputs in exact input order across pointer wrap.
- **Reset mid-operation:** with `count`=3, pulse `rst_n` low between clock edges.
  - Expect `out_valid`=0, `count`=0 and `in_ready`=1 immediately.
  - The next push appears at the head, with no stale data.
- **Counter saturation (macro defined):** drop 260 invalid commands.
  - Expect `err_count`=255 and 260 `err_pulse` cycles.
